// File: rtl/matrix_mul_pkg.sv
// matrix_mul_pkg: shared types and helpers for the sequential matrix multiplier.
// Provides the FSM state encoding, the default overflow-free accumulator width
// and flat-bus element offset helpers for A, B and C.
package matrix_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Product needs 2*w bits, summing m of them adds clog2(m), plus one for sign.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned m);
    return 2 * w + $clog2(m) + 1;
  endfunction

  // Counter width that stays at least one bit for a dimension of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of A(i,k) in the flat A bus.
  function automatic int unsigned a_off(input int unsigned i, input int unsigned k,
                                        input int unsigned m, input int unsigned w);
    return (i * m + k) * w;
  endfunction

  // Bit offset of B(k,j) in the flat B bus.
  function automatic int unsigned b_off(input int unsigned k, input int unsigned j,
                                        input int unsigned p, input int unsigned w);
    return (k * p + j) * w;
  endfunction

  // Bit offset of C(i,j) in the flat result bus.
  function automatic int unsigned c_off(input int unsigned i, input int unsigned j,
                                        input int unsigned p, input int unsigned acc_w);
    return (i * p + j) * acc_w;
  endfunction

endpackage

// File: rtl/matrix_mac.sv
// matrix_mac: single multiply-accumulate lane.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   clear            zero the accumulator (wins over en)
//   en               accumulate x*y this cycle
//   signed_mode      1 = sign-extend operands, 0 = zero-extend
//   x, y             W-bit operands
//   acc              registered running sum
//   sum_c            combinational acc + x*y (lets the caller store the final
//                    sum in the same cycle the accumulator is cleared)
module matrix_mac #(
  parameter int unsigned W     = 32,
  parameter int unsigned ACC_W = 66
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             signed_mode,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] sum_c
);

  localparam int unsigned EXT_W = ACC_W - W;

  logic [ACC_W-1:0] x_ext_c;
  logic [ACC_W-1:0] y_ext_c;
  logic [ACC_W-1:0] prod_c;

  // Extending to ACC_W first makes the truncated product correct modulo 2^ACC_W
  // in both signed and unsigned modes.
  always_comb begin
    x_ext_c = {{EXT_W{signed_mode & x[W-1]}}, x};
    y_ext_c = {{EXT_W{signed_mode & y[W-1]}}, y};
    prod_c  = x_ext_c * y_ext_c;
    sum_c   = acc + prod_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_c;
    end
  end

endmodule

// File: rtl/matrix_mul_seq.sv
// matrix_mul_seq: sequential C = A x B, one MAC per clock.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   start          request, accepted only while idle
//   signed_mode    operand signedness, captured with start
//   a              A(i,k) at [(i*M+k)*W +: W]
//   b              B(k,j) at [(k*P+j)*W +: W]
//   busy           high while not idle
//   done           one-cycle pulse when result updates
//   result         C(i,j) at [(i*P+j)*ACC_W +: ACC_W], held between pulses
module matrix_mul_seq
  import matrix_mul_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 2,
  parameter int unsigned P     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned ACC_W = acc_width(W, M)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic [N*M*W-1:0]       a,
  input  logic [M*P*W-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [N*P*ACC_W-1:0]   result
);

  localparam int unsigned IW       = cnt_width(N);
  localparam int unsigned JW       = cnt_width(P);
  localparam int unsigned KW       = cnt_width(M);
  localparam int unsigned AI_W     = $clog2(N * M * W);
  localparam int unsigned BI_W     = $clog2(M * P * W);
  localparam int unsigned CI_W     = $clog2(N * P * ACC_W);
  localparam int unsigned LAST_OFF = c_off(N - 1, P - 1, P, ACC_W);

  state_t                 state;
  logic [IW-1:0]          i;
  logic [JW-1:0]          j;
  logic [KW-1:0]          k;
  logic [N*M*W-1:0]       a_q;
  logic [M*P*W-1:0]       b_q;
  logic                   mode_q;
  logic [N*P*ACC_W-1:0]   wbuf;

  logic [AI_W-1:0]        a_base_c;
  logic [BI_W-1:0]        b_base_c;
  logic [CI_W-1:0]        c_base_c;
  logic [W-1:0]           mac_x_c;
  logic [W-1:0]           mac_y_c;
  logic                   mac_en_c;
  logic                   mac_clr_c;
  logic                   i_last_c;
  logic                   j_last_c;
  logic                   k_last_c;
  logic [ACC_W-1:0]       mac_acc;
  logic [ACC_W-1:0]       mac_sum_c;

  // Operand selection and MAC control for the current (i,j,k).
  always_comb begin
    a_base_c  = AI_W'(a_off(32'(i), 32'(k), M, W));
    b_base_c  = BI_W'(b_off(32'(k), 32'(j), P, W));
    c_base_c  = CI_W'(c_off(32'(i), 32'(j), P, ACC_W));
    mac_x_c   = a_q[a_base_c +: W];
    mac_y_c   = b_q[b_base_c +: W];
    i_last_c  = (i == IW'(N - 1));
    j_last_c  = (j == JW'(P - 1));
    k_last_c  = (k == KW'(M - 1));
    mac_en_c  = (state == MAC);
    mac_clr_c = (state == LOAD) || ((state == MAC) && k_last_c);
  end

  matrix_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk         (clk),
    .reset       (reset),
    .clear       (mac_clr_c),
    .en          (mac_en_c),
    .signed_mode (mode_q),
    .x           (mac_x_c),
    .y           (mac_y_c),
    .acc         (mac_acc),
    .sum_c       (mac_sum_c)
  );

  // Control FSM, index counters, capture registers, work buffer and output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      wbuf   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= signed_mode;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          i     <= '0;
          j     <= '0;
          k     <= '0;
          state <= MAC;
        end
        MAC: begin
          if (k_last_c) begin
            wbuf[c_base_c +: ACC_W] <= mac_sum_c;
            k <= '0;
            if (j_last_c) begin
              j <= '0;
              if (i_last_c) begin
                i     <= '0;
                state <= DONE;
                // Publish on entry to DONE so done and result share that cycle;
                // the last element bypasses the buffer it is being written to.
                done   <= 1'b1;
                result <= wbuf;
                result[LAST_OFF +: ACC_W] <= mac_sum_c;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// tb_matrix_mul_seq: directed self-checking bench for matrix_mul_seq.
// Small instance (2x2x2, W=8, ACC_W=18) and default instance (4x2x4, W=32).
module tb_matrix_mul_seq;

  logic          clk;
  logic          reset;

  logic          s_start, s_sm;
  logic [31:0]   s_a, s_b;
  logic          s_busy, s_done;
  logic [71:0]   s_result;

  logic          d_start, d_sm;
  logic [255:0]  d_a, d_b;
  logic          d_busy, d_done;
  logic [1055:0] d_result;

  int checks;
  int errors;

  matrix_mul_seq #(.N(2), .M(2), .P(2), .W(8)) dut_s (
    .clk         (clk),
    .reset       (reset),
    .start       (s_start),
    .signed_mode (s_sm),
    .a           (s_a),
    .b           (s_b),
    .busy        (s_busy),
    .done        (s_done),
    .result      (s_result)
  );

  matrix_mul_seq dut_d (
    .clk         (clk),
    .reset       (reset),
    .start       (d_start),
    .signed_mode (d_sm),
    .a           (d_a),
    .b           (d_b),
    .busy        (d_busy),
    .done        (d_done),
    .result      (d_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element (i,k) of a 2x2 byte matrix at [(i*2+k)*8 +: 8].
  function automatic logic [31:0] pack8(input int e00, input int e01, input int e10, input int e11);
    return {8'(e11), 8'(e10), 8'(e01), 8'(e00)};
  endfunction

  // Element (i,j) of a 2x2 result at [(i*2+j)*18 +: 18].
  function automatic logic [71:0] pack_r(input int r00, input int r01, input int r10, input int r11);
    return {18'(r11), 18'(r10), 18'(r01), 18'(r00)};
  endfunction

  // Launch one small-instance operation; returns at the done cycle (or after a
  // bound). Operands are scrambled after capture; optional second start at inj_cyc.
  task automatic op_s(input logic [31:0] a, input logic [31:0] b, input logic sm,
                      input int inj_cyc, output logic [71:0] res,
                      output int done_cyc, output int busy_hi);
    int cnt;
    cnt = 0;
    done_cyc = -1;
    busy_hi = 0;
    res = '0;
    @(negedge clk);
    s_a = a; s_b = b; s_sm = sm; s_start = 1'b1;
    while (done_cyc < 0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (s_busy) busy_hi++;
      if (s_done) begin
        done_cyc = cnt;
        res = s_result;
      end
      if (cnt == 1) begin
        s_start = 1'b0;
        s_a = $urandom;
        s_b = $urandom;
        s_sm = ~sm;
      end
      if (inj_cyc > 0 && cnt == inj_cyc) begin
        s_start = 1'b1;
        s_a = 32'h11111111;
        s_b = 32'h22222222;
      end
      if (inj_cyc > 0 && cnt == inj_cyc + 1) s_start = 1'b0;
    end
    s_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    s_start = 1'b1; s_sm = 1'b0; s_a = pack8(1, 2, 3, 4); s_b = pack8(5, 6, 7, 8);
    d_start = 1'b1; d_sm = 1'b0; d_a = '1; d_b = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_small_ctl busy=%b done=%b expected 0 0", s_busy, s_done);
    end
    checks++;
    if (s_result !== 72'd0) begin
      errors++;
      $display("FAIL reset_small_result got %h expected 0", s_result);
    end
    checks++;
    if (d_busy !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_dflt_ctl busy=%b done=%b expected 0 0", d_busy, d_done);
    end
    checks++;
    if (d_result !== 1056'd0) begin
      errors++;
      $display("FAIL reset_dflt_result nonzero after reset");
    end
    s_start = 1'b0;
    d_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_dropped s_busy=%b d_busy=%b expected 0 0", s_busy, d_busy);
    end
  endtask

  task automatic test_basic();
    logic [71:0] res;
    int dc, bh;
    op_s(pack8(1, 2, 3, 4), pack8(5, 6, 7, 8), 1'b0, 0, res, dc, bh);
    checks++;
    if (res !== pack_r(19, 22, 43, 50)) begin
      errors++;
      $display("FAIL basic_result got %h expected %h", res, pack_r(19, 22, 43, 50));
    end
    checks++;
    if (dc !== 10) begin
      errors++;
      $display("FAIL basic_latency got %0d expected 10", dc);
    end
    checks++;
    if (bh !== 10) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d expected 10", bh);
    end
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_done busy=%b done=%b expected 0 0", s_busy, s_done);
    end
    checks++;
    if (s_result !== pack_r(19, 22, 43, 50)) begin
      errors++;
      $display("FAIL basic_hold got %h expected %h", s_result, pack_r(19, 22, 43, 50));
    end
  endtask

  task automatic test_signed();
    logic [71:0] res;
    int dc, bh;
    op_s(pack8(-1, 2, 3, -4), pack8(1, 0, 0, 1), 1'b1, 0, res, dc, bh);
    checks++;
    if (res !== pack_r(-1, 2, 3, -4)) begin
      errors++;
      $display("FAIL signed_identity got %h expected %h", res, pack_r(-1, 2, 3, -4));
    end
    op_s(pack8(-1, 2, 3, -4), pack8(1, 0, 0, 1), 1'b0, 0, res, dc, bh);
    checks++;
    if (res !== pack_r(255, 2, 3, 252)) begin
      errors++;
      $display("FAIL unsigned_identity got %h expected %h", res, pack_r(255, 2, 3, 252));
    end
  endtask

  task automatic test_width();
    logic [71:0] res;
    int dc, bh;
    op_s(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, res, dc, bh);
    checks++;
    if (res !== pack_r(130050, 130050, 130050, 130050)) begin
      errors++;
      $display("FAIL width_unsigned_max got %h expected %h", res, pack_r(130050, 130050, 130050, 130050));
    end
    op_s(32'h80808080, 32'h80808080, 1'b1, 0, res, dc, bh);
    checks++;
    if (res !== pack_r(32768, 32768, 32768, 32768)) begin
      errors++;
      $display("FAIL width_signed_min got %h expected %h", res, pack_r(32768, 32768, 32768, 32768));
    end
  endtask

  task automatic test_start_busy();
    logic [71:0] res;
    int dc, bh, extra;
    op_s(pack8(1, 2, 3, 4), pack8(5, 6, 7, 8), 1'b0, 5, res, dc, bh);
    checks++;
    if (res !== pack_r(19, 22, 43, 50) || dc !== 10) begin
      errors++;
      $display("FAIL busy_start_first got %h at %0d expected %h at 10", res, dc, pack_r(19, 22, 43, 50));
    end
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (s_done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_start_extra_done got %0d expected 0", extra);
    end
    checks++;
    if (s_result !== pack_r(19, 22, 43, 50)) begin
      errors++;
      $display("FAIL busy_start_result_kept got %h expected %h", s_result, pack_r(19, 22, 43, 50));
    end
  endtask

  task automatic test_back_to_back();
    logic [71:0] res;
    int dc, bh;
    op_s(pack8(-1, 2, 3, -4), pack8(1, 0, 0, 1), 1'b1, 0, res, dc, bh);
    // Next call drives start in the first idle cycle after done.
    op_s(pack8(1, 2, 3, 4), pack8(5, 6, 7, 8), 1'b0, 0, res, dc, bh);
    checks++;
    if (res !== pack_r(19, 22, 43, 50) || dc !== 10) begin
      errors++;
      $display("FAIL back_to_back got %h at %0d expected %h at 10", res, dc, pack_r(19, 22, 43, 50));
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] res;
    int dc, bh, extra;
    @(negedge clk);
    s_a = pack8(2, 0, 0, 2); s_b = pack8(3, 0, 0, 3); s_sm = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_result !== 72'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b result=%h expected 0 0 0", s_busy, s_done, s_result);
    end
    reset = 1'b1;
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (s_done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d expected 0", extra);
    end
    op_s(pack8(2, 0, 0, 2), pack8(3, 0, 0, 3), 1'b0, 0, res, dc, bh);
    checks++;
    if (res !== pack_r(6, 0, 0, 6) || dc !== 10) begin
      errors++;
      $display("FAIL reset_mid_restart got %h at %0d expected %h at 10", res, dc, pack_r(6, 0, 0, 6));
    end
  endtask

  task automatic test_default();
    longint exp_c [4][4];
    int cnt, dc;
    logic [1055:0] res;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++)
        d_a[(i * 2 + k) * 32 +: 32] = 32'(i + k + 1);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++)
        d_b[(k * 4 + j) * 32 +: 32] = 32'(k * 4 + j + 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        exp_c[i][j] = 0;
        for (int k = 0; k < 2; k++)
          exp_c[i][j] += longint'(i + k + 1) * longint'(k * 4 + j + 1);
      end
    @(negedge clk);
    d_sm = 1'b0;
    d_start = 1'b1;
    cnt = 0;
    dc = -1;
    res = '0;
    while (dc < 0 && cnt < 60) begin
      @(negedge clk);
      cnt++;
      d_start = 1'b0;
      if (d_done) begin
        dc = cnt;
        res = d_result;
      end
    end
    checks++;
    if (dc !== 34) begin
      errors++;
      $display("FAIL default_latency got %0d expected 34", dc);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (res[(i * 4 + j) * 66 +: 66] !== 66'(exp_c[i][j])) begin
          errors++;
          $display("FAIL default_c%0d%0d got %0d expected %0d", i, j,
                   res[(i * 4 + j) * 66 +: 66], exp_c[i][j]);
        end
      end
    @(negedge clk);
    checks++;
    if (d_busy !== 1'b0) begin
      errors++;
      $display("FAIL default_idle busy=%b expected 0", d_busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    s_start = 1'b0; s_sm = 1'b0; s_a = '0; s_b = '0;
    d_start = 1'b0; d_sm = 1'b0; d_a = '0; d_b = '0;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_width();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_default();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
